// File: rtl/key_filter_pkg.sv
// key_filter_pkg: state encoding and constants shared by the key debouncer.
// Used by key_filter_ch and key_filter_multi.
package key_filter_pkg;

   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      PRESS_FILTER   = 2'd1,
      PRESSED        = 2'd2,
      RELEASE_FILTER = 2'd3
   } kf_state_e;

   localparam logic KEY_RELEASED = 1'b1;

   function automatic logic is_held(input kf_state_e s);
      return (s == PRESSED) || (s == RELEASE_FILTER);
   endfunction

endpackage

// File: rtl/key_filter_multi_if.sv
// key_filter_multi_if: raw key inputs and debounced event outputs.
// master drives keys, slave is the debouncer.
interface key_filter_multi_if #(
   parameter int KEY_NUM = 4
);
   logic [KEY_NUM-1:0] key_in;
   logic [KEY_NUM-1:0] key_flag;
   logic [KEY_NUM-1:0] key_release;
   logic [KEY_NUM-1:0] key_state;
   logic [KEY_NUM-1:0] key_long;

   modport master (
      output key_in,
      input  key_flag,
      input  key_release,
      input  key_state,
      input  key_long
   );

   modport slave (
      input  key_in,
      output key_flag,
      output key_release,
      output key_state,
      output key_long
   );
endinterface

// File: rtl/key_filter_ch.sv
// key_filter_ch: one key channel - 2-flop sync, debounce FSM, counters.
// Long-press logic present only with KEY_FILTER_LONG_PRESS_EN defined.
module key_filter_ch
   import key_filter_pkg::*;
#(
   parameter int CNT_MAX  = 999_999,
   parameter int LONG_MAX = 50_000_000
)(
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_i,
   output logic flag_o,
   output logic release_o,
   output logic state_o,
   output logic long_o
);
   localparam int CW = $clog2(CNT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   logic          sync1_q, sync2_q;
   kf_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;
   logic          rel_q, rel_d;
   logic          st_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= KEY_RELEASED;
         sync2_q <= KEY_RELEASED;
         state_q <= IDLE;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         rel_q   <= 1'b0;
         st_q    <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         rel_q   <= rel_d;
         st_q    <= is_held(state_d);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flag_d  = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!sync2_q) begin
               state_d = PRESS_FILTER;
               cnt_d   = '0;
            end
         end
         PRESS_FILTER: begin
            if (sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               flag_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (sync2_q) begin
               state_d = RELEASE_FILTER;
               cnt_d   = '0;
            end
         end
         RELEASE_FILTER: begin
            if (!sync2_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   assign flag_o    = flag_q;
   assign release_o = rel_q;
   assign state_o   = st_q;

`ifdef KEY_FILTER_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_MAX);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);

   logic [LW-1:0] lcnt_q, lcnt_d;
   logic          ldone_q, ldone_d;
   logic          long_q, long_d;
   logic          enter_press;

   // Only a fresh press clears the hold; a release glitch keeps it.
   assign enter_press = (state_q == PRESS_FILTER) && (state_d == PRESSED);

   always_comb begin
      lcnt_d  = lcnt_q;
      ldone_d = ldone_q;
      long_d  = 1'b0;
      if (enter_press) begin
         lcnt_d  = '0;
         ldone_d = 1'b0;
      end else if ((state_q == PRESSED) && !sync2_q) begin
         if (lcnt_q != LONG_LAST) begin
            lcnt_d = lcnt_q + 1'b1;
         end else if (!ldone_q) begin
            long_d  = 1'b1;
            ldone_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lcnt_q  <= '0;
         ldone_q <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         lcnt_q  <= lcnt_d;
         ldone_q <= ldone_d;
         long_q  <= long_d;
      end
   end

   assign long_o = long_q;
`else
   assign long_o = 1'b0 & (LONG_MAX > 0);
`endif

endmodule

// File: rtl/key_filter_multi.sv
// key_filter_multi: KEY_NUM independent key debounce channels.
// Long-press events require KEY_FILTER_LONG_PRESS_EN.
module key_filter_multi
   import key_filter_pkg::*;
#(
   parameter int KEY_NUM  = 4,
   parameter int CNT_MAX  = 999_999,
   parameter int LONG_MAX = 50_000_000
)(
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   key_filter_multi_if.slave  kif
);
   logic [KEY_NUM-1:0] flag_w;
   logic [KEY_NUM-1:0] rel_w;
   logic [KEY_NUM-1:0] st_w;
   logic [KEY_NUM-1:0] long_w;

   for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
      key_filter_ch #(
         .CNT_MAX  (CNT_MAX),
         .LONG_MAX (LONG_MAX)
      ) u_ch (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .key_i     (kif.key_in[g]),
         .flag_o    (flag_w[g]),
         .release_o (rel_w[g]),
         .state_o   (st_w[g]),
         .long_o    (long_w[g])
      );
   end

   assign kif.key_flag    = flag_w;
   assign kif.key_release = rel_w;
   assign kif.key_state   = st_w;
   assign kif.key_long    = long_w;

endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi: directed vectors plus bounce and reset sequences
// for key_filter_multi with CNT_MAX=24, LONG_MAX=100.
module tb_key_filter_multi;
   localparam int KN = 4;
   localparam int CM = 24;
   localparam int LM = 100;
   localparam int LAT = CM + 3;

   logic sys_clk;
   logic sys_rst_n;

   key_filter_multi_if #(.KEY_NUM(KN)) kif ();

   key_filter_multi #(
      .KEY_NUM  (KN),
      .CNT_MAX  (CM),
      .LONG_MAX (LM)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .kif       (kif.slave)
   );

   initial sys_clk = 1'b0;
   always #10 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int ch;
      int kind;
   } ev_t;

   ev_t evq[$];
   int  both_cnt = 0;
   int  n_cmp = 0;
   int  n_bad = 0;

   always @(negedge sys_clk) begin
      for (int i = 0; i < KN; i++) begin
         if (kif.key_flag[i])    evq.push_back('{cyc, i, 0});
         if (kif.key_release[i]) evq.push_back('{cyc, i, 1});
         if (kif.key_long[i])    evq.push_back('{cyc, i, 2});
      end
      if (|(kif.key_flag & kif.key_release)) both_cnt++;
   end

   function automatic int ev_count(int kind, int ch);
      int n = 0;
      foreach (evq[k]) if (evq[k].kind == kind && evq[k].ch == ch) n++;
      return n;
   endfunction

   function automatic int ev_first(int kind, int ch);
      foreach (evq[k])
         if (evq[k].kind == kind && evq[k].ch == ch) return evq[k].c;
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic outs_zero(input string name);
      chk({name, "_flag"},  int'(kif.key_flag),    0);
      chk({name, "_rel"},   int'(kif.key_release), 0);
      chk({name, "_state"}, int'(kif.key_state),   0);
      chk({name, "_long"},  int'(kif.key_long),    0);
   endtask

   typedef struct {
      logic [3:0] mask;
      int         len;
      logic [3:0] exp_flag;
      logic [3:0] exp_mid;
      logic [3:0] exp_long;
   } vec_t;

   vec_t vt[5];

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, r, m, q, last_hi, el;
      logic b;

      vt[0] = '{4'b0001, 200, 4'b0001, 4'b0001, 4'b0001};
      vt[1] = '{4'b0001,  20, 4'b0000, 4'b0000, 4'b0000};
      vt[2] = '{4'b1001,  60, 4'b1001, 4'b1001, 4'b0000};
      vt[3] = '{4'b0010,  25, 4'b0010, 4'b0000, 4'b0000};
      vt[4] = '{4'b0100,  24, 4'b0000, 4'b0000, 4'b0000};

      sys_rst_n  = 1'b0;
      kif.key_in = '1;
      repeat (3) @(negedge sys_clk);
      outs_zero("reset");
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);

      for (int k = 0; k < 5; k++) begin
         evq.delete();
         @(negedge sys_clk);
         c = cyc;
         kif.key_in = ~vt[k].mask;
         m = (vt[k].len < 30) ? vt[k].len : 30;
         repeat (m) @(negedge sys_clk);
         chk($sformatf("v%0d_state_mid", k), int'(kif.key_state),
             int'(vt[k].exp_mid));
         repeat (vt[k].len - m) @(negedge sys_clk);
         r = cyc;
         kif.key_in = '1;
         repeat (80) @(negedge sys_clk);
         chk($sformatf("v%0d_state_end", k), int'(kif.key_state), 0);
         for (int i = 0; i < KN; i++) begin
`ifdef KEY_FILTER_LONG_PRESS_EN
            el = int'(vt[k].exp_long[i]);
`else
            el = 0;
`endif
            chk($sformatf("v%0d_ch%0d_nflag", k, i), ev_count(0, i),
                int'(vt[k].exp_flag[i]));
            chk($sformatf("v%0d_ch%0d_nrel", k, i), ev_count(1, i),
                int'(vt[k].exp_flag[i]));
            chk($sformatf("v%0d_ch%0d_nlong", k, i), ev_count(2, i), el);
            if (vt[k].exp_flag[i]) begin
               chk($sformatf("v%0d_ch%0d_tflag", k, i), ev_first(0, i),
                   c + LAT);
               chk($sformatf("v%0d_ch%0d_trel", k, i), ev_first(1, i),
                   r + LAT);
            end
            if (el != 0)
               chk($sformatf("v%0d_ch%0d_tlong", k, i), ev_first(2, i),
                   c + LAT + LM);
         end
      end

      // bouncing press on ch0
      evq.delete();
      @(negedge sys_clk);
      last_hi = cyc;
      for (int j = 0; j < 30; j++) begin
         @(negedge sys_clk);
         b = (j % 8 == 7) ? 1'b1 : 1'($urandom_range(0, 1));
         kif.key_in[0] = b;
         if (b) last_hi = cyc;
      end
      @(negedge sys_clk);
      kif.key_in[0] = 1'b0;
      repeat (60) @(negedge sys_clk);
      chk("bounce_nflag", ev_count(0, 0), 1);
      chk("bounce_tflag", ev_first(0, 0), last_hi + 1 + LAT);
      chk("bounce_state", int'(kif.key_state), 1);
      kif.key_in = '1;
      repeat (60) @(negedge sys_clk);
      chk("bounce_nrel", ev_count(1, 0), 1);

      // reset in the middle of a press window
      evq.delete();
      @(negedge sys_clk);
      c = cyc;
      kif.key_in = 4'b1110;
      repeat (13) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      outs_zero("midrst");
      sys_rst_n = 1'b1;
      q = cyc;
      repeat (60) @(negedge sys_clk);
      chk("midrst_nflag", ev_count(0, 0), 1);
      chk("midrst_tflag", ev_first(0, 0), q + LAT);
      chk("midrst_state", int'(kif.key_state), 1);
      kif.key_in = '1;
      repeat (60) @(negedge sys_clk);
      chk("midrst_nrel", ev_count(1, 0), 1);
      chk("midrst_nlong", ev_count(2, 0), 0);

      chk("flag_rel_overlap", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
